// File: rtl/memory_controller.sv
// Byte-serial memory port initiator: assembles/splits 1/2/4-byte transfers for an
// instruction port and a data port. `MEM_CTRL_SIGN_EXT_EN adds data_signed for sub-word sign extension.
module memory_controller #(
  parameter int ADDR_WIDTH = 17,
  parameter int LEN        = 32,
  parameter int BYTE_SIZE  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_req,
  input  logic [ADDR_WIDTH-1:0] inst_addr,
  output logic [LEN-1:0]        inst_data,
  output logic                  inst_done,
  input  logic                  data_req,
  input  logic                  data_we,
  input  logic [1:0]            data_size,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [LEN-1:0]        data_wdata,
`ifdef MEM_CTRL_SIGN_EXT_EN
  input  logic                  data_signed,
`endif
  output logic [LEN-1:0]        data_rdata,
  output logic                  data_done,
  output logic [1:0]            mem_vis_signal,
  output logic [ADDR_WIDTH-1:0] mem_vis_addr,
  output logic [BYTE_SIZE-1:0]  writen_data,
  input  logic [BYTE_SIZE-1:0]  mem_data
);

  localparam int NB = LEN / BYTE_SIZE;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_INST_RD = 3'd1;
  localparam logic [2:0] S_DATA_RD = 3'd2;
  localparam logic [2:0] S_DATA_WR = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [1:0] CMD_IDLE      = 2'b00;
  localparam logic [1:0] CMD_READ_INST = 2'b01;
  localparam logic [1:0] CMD_READ_DATA = 2'b10;
  localparam logic [1:0] CMD_WRITE     = 2'b11;

  // Requesters hold req until their done pulse; the DONE cycle keeps a
  // still-high stale request from being re-accepted.
  logic [2:0]            state;
  logic [2:0]            cnt;
  logic [2:0]            nbytes;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN-1:0]        wdata_q;
  logic [LEN-1:0]        rd_buf;
  logic                  signed_q;

  logic                  signed_in;
  logic [2:0]            size_n;
  logic [2:0]            next_idx;
  logic [2:0]            cap_idx;
  logic [LEN-1:0]        merged;
  logic [LEN-1:0]        extended;
  logic [BYTE_SIZE-1:0]  wr_byte;
  logic                  sign_bit;
  logic                  fill;

`ifdef MEM_CTRL_SIGN_EXT_EN
  assign signed_in = data_signed;
`else
  assign signed_in = 1'b0;
`endif

  always_comb begin
    case (data_size)
      2'b00:   size_n = 3'd1;
      2'b01:   size_n = 3'd2;
      default: size_n = 3'd4;
    endcase
  end

  // cnt holds the number of edges since acceptance minus one, so at the
  // current edge byte cnt+1 is issued and byte cnt-1 is captured.
  assign next_idx = cnt + 3'd1;
  assign cap_idx  = cnt - 3'd1;

  always_comb begin
    merged = rd_buf;
    for (int b = 0; b < NB; b++) begin
      if (cap_idx == 3'(b)) begin
        merged[b*BYTE_SIZE +: BYTE_SIZE] = mem_data;
      end
    end
  end

  always_comb begin
    case (nbytes)
      3'd1:    sign_bit = merged[BYTE_SIZE-1];
      3'd2:    sign_bit = merged[2*BYTE_SIZE-1];
      default: sign_bit = merged[LEN-1];
    endcase
    fill     = signed_q & sign_bit;
    extended = merged;
    for (int i = BYTE_SIZE; i < LEN; i++) begin
      if (i >= int'(nbytes) * BYTE_SIZE) begin
        extended[i] = fill;
      end
    end
  end

  always_comb begin
    wr_byte = '0;
    for (int b = 0; b < NB; b++) begin
      if (next_idx == 3'(b)) begin
        wr_byte = wdata_q[b*BYTE_SIZE +: BYTE_SIZE];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      nbytes         <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      rd_buf         <= '0;
      signed_q       <= 1'b0;
      mem_vis_signal <= CMD_IDLE;
      mem_vis_addr   <= '0;
      writen_data    <= '0;
      inst_done      <= 1'b0;
      data_done      <= 1'b0;
      inst_data      <= '0;
      data_rdata     <= '0;
    end else begin
      inst_done <= 1'b0;
      data_done <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt    <= '0;
          rd_buf <= '0;
          if (data_req) begin
            addr_q       <= data_addr;
            wdata_q      <= data_wdata;
            nbytes       <= size_n;
            signed_q     <= signed_in;
            mem_vis_addr <= data_addr;
            if (data_we) begin
              state          <= S_DATA_WR;
              mem_vis_signal <= CMD_WRITE;
              writen_data    <= data_wdata[BYTE_SIZE-1:0];
            end else begin
              state          <= S_DATA_RD;
              mem_vis_signal <= CMD_READ_DATA;
            end
          end else if (inst_req) begin
            addr_q         <= inst_addr;
            nbytes         <= 3'd4;
            signed_q       <= 1'b0;
            mem_vis_addr   <= inst_addr;
            state          <= S_INST_RD;
            mem_vis_signal <= CMD_READ_INST;
          end else begin
            mem_vis_signal <= CMD_IDLE;
          end
        end
        S_INST_RD, S_DATA_RD: begin
          cnt <= next_idx;
          if (cnt != 3'd0) begin
            rd_buf <= merged;
          end
          if (next_idx < nbytes) begin
            mem_vis_signal <= (state == S_INST_RD) ? CMD_READ_INST : CMD_READ_DATA;
            mem_vis_addr   <= addr_q + ADDR_WIDTH'(next_idx);
          end else begin
            mem_vis_signal <= CMD_IDLE;
          end
          if (cnt == nbytes) begin
            state <= S_DONE;
            if (state == S_INST_RD) begin
              inst_data <= extended;
              inst_done <= 1'b1;
            end else begin
              data_rdata <= extended;
              data_done  <= 1'b1;
            end
          end
        end
        S_DATA_WR: begin
          cnt <= next_idx;
          if (next_idx < nbytes) begin
            mem_vis_signal <= CMD_WRITE;
            mem_vis_addr   <= addr_q + ADDR_WIDTH'(next_idx);
            writen_data    <= wr_byte;
          end else begin
            mem_vis_signal <= CMD_IDLE;
            data_done      <= 1'b1;
            state          <= S_DONE;
          end
        end
        S_DONE: begin
          mem_vis_signal <= CMD_IDLE;
          state          <= S_IDLE;
        end
        default: begin
          mem_vis_signal <= CMD_IDLE;
          state          <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_controller.sv
// Bench for memory_controller: byte-wide memory model, vector table of data
// transfers, and directed sequences for inst read, arbitration, wrap, reset abort, toggling.
module tb_memory_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [16:0] inst_addr;
  logic [31:0] inst_data;
  logic        inst_done;
  logic        data_req;
  logic        data_we;
  logic [1:0]  data_size;
  logic [16:0] data_addr;
  logic [31:0] data_wdata;
`ifdef MEM_CTRL_SIGN_EXT_EN
  logic        data_signed;
`endif
  logic [31:0] data_rdata;
  logic        data_done;
  logic [1:0]  mem_vis_signal;
  logic [16:0] mem_vis_addr;
  logic [7:0]  writen_data;
  logic [7:0]  mem_data;

  int checks = 0;
  int failures = 0;
  int data_done_cnt = 0;
  int inst_done_cnt = 0;

  logic        poke_en = 1'b0;
  logic [16:0] poke_addr = '0;
  logic [7:0]  poke_val = '0;
  logic [7:0]  mem [0:131071];

  memory_controller dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_data(inst_data), .inst_done(inst_done),
    .data_req(data_req), .data_we(data_we), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata),
`ifdef MEM_CTRL_SIGN_EXT_EN
    .data_signed(data_signed),
`endif
    .data_rdata(data_rdata), .data_done(data_done),
    .mem_vis_signal(mem_vis_signal), .mem_vis_addr(mem_vis_addr),
    .writen_data(writen_data), .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  // Memory model: samples the command at the edge, read data valid after it.
  // The bus is ignored while rst is high, so a command met by reset is not performed.
  always @(posedge clk) begin
    if (poke_en) begin
      mem[poke_addr] <= poke_val;
    end else if (!rst) begin
      if (mem_vis_signal == 2'b11) mem[mem_vis_addr] <= writen_data;
      if (mem_vis_signal == 2'b01 || mem_vis_signal == 2'b10) mem_data <= mem[mem_vis_addr];
    end
  end

  always @(negedge clk) begin
    if (data_done) data_done_cnt++;
    if (inst_done) inst_done_cnt++;
  end

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic [16:0] addr;
    logic [31:0] wdata;
    logic        sgn;
    logic [31:0] exp_z;
    logic [31:0] exp_s;
  } vec_t;

  vec_t vecs[13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic poke(input logic [16:0] a, input logic [7:0] v);
    poke_en   = 1'b1;
    poke_addr = a;
    poke_val  = v;
    tick();
    poke_en   = 1'b0;
  endtask

  task automatic run_data(input string name, input logic we, input logic [1:0] size,
                          input logic [16:0] addr, input logic [31:0] wdata, input logic sgn,
                          input logic [31:0] exp_z, input logic [31:0] exp_s);
    int n;
    int d;
    logic [1:0]  exp_sig;
    logic [16:0] exp_addr;
    logic [31:0] exp_rd;
    n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    d = we ? n : n + 1;
`ifdef MEM_CTRL_SIGN_EXT_EN
    exp_rd = sgn ? exp_s : exp_z;
    data_signed = sgn;
`else
    exp_rd = exp_z;
    if (sgn && exp_s == 32'h0) exp_rd = 32'h0;
`endif
    data_req   = 1'b1;
    data_we    = we;
    data_size  = size;
    data_addr  = addr;
    data_wdata = wdata;
    for (int j = 0; j <= n + 3; j++) begin
      tick();
      exp_sig = (j < n) ? (we ? 2'b11 : 2'b10) : 2'b00;
      check({name, " cmd"}, mem_vis_signal, exp_sig);
      if (j < n) begin
        exp_addr = addr + 17'(j);
        check({name, " addr"}, mem_vis_addr, exp_addr);
        if (we) check({name, " wbyte"}, writen_data, (wdata >> (8 * j)) & 32'hFF);
      end
      check({name, " done"}, data_done, (j == d) ? 1'b1 : 1'b0);
      if (j == d && !we) check({name, " rdata"}, data_rdata, exp_rd);
      if (data_done) data_req = 1'b0;
    end
    data_req = 1'b0;
  endtask

  initial begin
    int dd_edge;
    int id_edge;
    int first_ri;
    int last_rd;
    int base;
    logic [1:0] trace [0:39];
    logic saw_write;

    vecs[0]  = '{1'b1, 2'b10, 17'h00100, 32'hDEADBEEF, 1'b0, 32'h0,        32'h0};
    vecs[1]  = '{1'b0, 2'b10, 17'h00100, 32'h0,        1'b0, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 2'b01, 17'h00200, 32'h12348001, 1'b0, 32'h0,        32'h0};
    vecs[3]  = '{1'b0, 2'b01, 17'h00200, 32'h0,        1'b1, 32'h00008001, 32'hFFFF8001};
    vecs[4]  = '{1'b1, 2'b00, 17'h00300, 32'h000000C3, 1'b0, 32'h0,        32'h0};
    vecs[5]  = '{1'b0, 2'b00, 17'h00300, 32'h0,        1'b1, 32'h000000C3, 32'hFFFFFFC3};
    vecs[6]  = '{1'b0, 2'b00, 17'h00300, 32'h0,        1'b0, 32'h000000C3, 32'h000000C3};
    vecs[7]  = '{1'b1, 2'b11, 17'h00400, 32'h01020304, 1'b0, 32'h0,        32'h0};
    vecs[8]  = '{1'b0, 2'b11, 17'h00400, 32'h0,        1'b0, 32'h01020304, 32'h01020304};
    vecs[9]  = '{1'b0, 2'b00, 17'h00101, 32'h0,        1'b1, 32'h000000BE, 32'hFFFFFFBE};
    vecs[10] = '{1'b1, 2'b10, 17'h1FFFE, 32'h44332211, 1'b0, 32'h0,        32'h0};
    vecs[11] = '{1'b0, 2'b10, 17'h1FFFE, 32'h0,        1'b0, 32'h44332211, 32'h44332211};
    vecs[12] = '{1'b0, 2'b01, 17'h00101, 32'h0,        1'b0, 32'h0000ADBE, 32'h0000ADBE};

    rst = 1'b1;
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_we = 1'b0; data_size = 2'b00; data_addr = '0; data_wdata = '0;
`ifdef MEM_CTRL_SIGN_EXT_EN
    data_signed = 1'b0;
`endif
    repeat (3) tick();
    check("reset signal", mem_vis_signal, 2'b00);
    check("reset addr", mem_vis_addr, 17'h0);
    check("reset wdata", writen_data, 8'h0);
    check("reset dones", {inst_done, data_done}, 2'b00);
    check("reset inst_data", inst_data, 32'h0);
    check("reset rdata", data_rdata, 32'h0);
    rst = 1'b0;
    tick();

    // Instruction read at 0x10, bytes 13 05 10 00: done exactly at E5.
    poke(17'h10, 8'h13); poke(17'h11, 8'h05); poke(17'h12, 8'h10); poke(17'h13, 8'h00);
    inst_req = 1'b1; inst_addr = 17'h00010;
    for (int j = 0; j <= 8; j++) begin
      tick();
      check("inst cmd", mem_vis_signal, (j < 4) ? 2'b01 : 2'b00);
      if (j < 4) check("inst addr", mem_vis_addr, 17'h10 + 17'(j));
      check("inst done", inst_done, (j == 5) ? 1'b1 : 1'b0);
      check("inst no data_done", data_done, 1'b0);
      if (j == 5) check("inst data", inst_data, 32'h00100513);
      if (inst_done) inst_req = 1'b0;
    end
    inst_req = 1'b0;

    for (int i = 0; i < 13; i++) begin
      run_data($sformatf("vec%0d", i), vecs[i].we, vecs[i].size, vecs[i].addr,
               vecs[i].wdata, vecs[i].sgn, vecs[i].exp_z, vecs[i].exp_s);
    end

    // Simultaneous requests: data read first, one DONE cycle, then the inst read.
    data_req = 1'b1; data_we = 1'b0; data_size = 2'b10; data_addr = 17'h00100;
    inst_req = 1'b1; inst_addr = 17'h00010;
    dd_edge = -1; id_edge = -1; first_ri = -1; last_rd = -1; saw_write = 1'b0;
    for (int j = 0; j < 40; j++) begin
      tick();
      trace[j] = mem_vis_signal;
      if (mem_vis_signal == 2'b11) saw_write = 1'b1;
      if (mem_vis_signal == 2'b10) last_rd = j;
      if (mem_vis_signal == 2'b01 && first_ri < 0) first_ri = j;
      if (data_done && dd_edge < 0) begin
        dd_edge = j; data_req = 1'b0;
        check("arb rdata", data_rdata, 32'hDEADBEEF);
      end
      if (inst_done && id_edge < 0) begin
        id_edge = j; inst_req = 1'b0;
        check("arb inst_data", inst_data, 32'h00100513);
      end
    end
    data_req = 1'b0; inst_req = 1'b0;
    check("arb data done edge", 32'(dd_edge), 32'd5);
    check("arb inst done edge", 32'(id_edge), 32'd12);
    check("arb last data cmd", 32'(last_rd), 32'd3);
    check("arb first inst cmd", 32'(first_ri), 32'd7);
    check("arb idle gap", {trace[4], trace[5], trace[6]}, 6'b0);
    check("arb no write", saw_write, 1'b0);

    // Half read straddling the top of the address space.
    poke(17'h1FFFF, 8'h80); poke(17'h00000, 8'hFF);
    run_data("wrap half", 1'b0, 2'b01, 17'h1FFFF, 32'h0, 1'b1, 32'h0000FF80, 32'hFFFFFF80);

    // Reset at E2 of a word write: only byte 0 lands.
    poke(17'h500, 8'h00); poke(17'h501, 8'h00); poke(17'h502, 8'h00); poke(17'h503, 8'h00);
    base = data_done_cnt;
    data_req = 1'b1; data_we = 1'b1; data_size = 2'b10; data_addr = 17'h00500;
    data_wdata = 32'h11223344;
    tick();
    check("abort E0 cmd", {mem_vis_signal, mem_vis_addr}, {2'b11, 17'h500});
    tick();
    check("abort E1 cmd", {mem_vis_signal, mem_vis_addr}, {2'b11, 17'h501});
    rst = 1'b1;
    tick();
    check("abort E2 cmd", mem_vis_signal, 2'b00);
    check("abort E2 addr", mem_vis_addr, 17'h0);
    rst = 1'b0; data_req = 1'b0; data_we = 1'b0;
    repeat (6) tick();
    check("abort no done", 32'(data_done_cnt - base), 32'd0);
    check("abort byte0", mem[17'h500], 8'h44);
    check("abort byte1", mem[17'h501], 8'h00);
    check("abort byte2-3", {mem[17'h502], mem[17'h503]}, 16'h0);

    // Byte read with inputs thrashed after acceptance.
    poke(17'h600, 8'h7F); poke(17'h777, 8'h00);
    base = data_done_cnt;
    data_req = 1'b1; data_we = 1'b0; data_size = 2'b00; data_addr = 17'h00600;
    tick();
    check("toggle E0 cmd", {mem_vis_signal, mem_vis_addr}, {2'b10, 17'h600});
    data_we = 1'b1; data_size = 2'b10; data_addr = 17'h00777; data_wdata = 32'hFFFFFFFF;
    inst_req = 1'b1;
    tick();
    check("toggle E1 cmd", mem_vis_signal, 2'b00);
    data_req = 1'b0; inst_req = 1'b0;
    tick();
    check("toggle done", data_done, 1'b1);
    check("toggle rdata", data_rdata, 32'h0000007F);
    repeat (4) tick();
    check("toggle done once", 32'(data_done_cnt - base), 32'd1);
    check("toggle idle state", dut.state, 3'd0);
    check("toggle bus idle", mem_vis_signal, 2'b00);
    check("toggle no write", mem[17'h777], 8'h00);
    data_we = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
